// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock through a registered carry.
// Optional macro SEQ_CHUNK_ADDER_CARRY_VEC_EN adds the per-bit carry output carry_vec.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
`ifdef SEQ_CHUNK_ADDER_CARRY_VEC_EN
    ,
    output logic [WIDTH-1:0] carry_vec
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] psum_s;
    logic [CHUNK:0]   c_s;
    logic             last_s;
    logic             accept_s;

    assign accept_s  = (state_r == ST_IDLE) && start;
    assign last_s    = (idx_r == IW'(NCHUNK - 1));
    assign a_chunk_s = a_r[int'(idx_r) * CHUNK +: CHUNK];
    assign b_chunk_s = b_r[int'(idx_r) * CHUNK +: CHUNK];

    // Ripple one chunk combinationally, starting from the registered carry
    always_comb begin
        c_s    = '0;
        psum_s = '0;
        c_s[0] = carry_r;
        for (int j = 0; j < CHUNK; j++) begin
            psum_s[j]  = a_chunk_s[j] ^ b_chunk_s[j] ^ c_s[j];
            c_s[j + 1] = (a_chunk_s[j] & b_chunk_s[j]) | (c_s[j] & (a_chunk_s[j] ^ b_chunk_s[j]));
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (state_s == ST_IDLE);
            busy  <= (state_s != ST_IDLE);
            done  <= (state_s == ST_DONE);
        end
    end

    // Operand capture and chunk-by-chunk accumulation; B and carry are pre-inverted for subtract
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= '0;
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? ~cin : cin;
        end else if (state_r == ST_RUN) begin
            sum[int'(idx_r) * CHUNK +: CHUNK] <= psum_s;
            carry_r <= c_s[CHUNK];
            if (last_s) begin
                idx_r    <= '0;
                cout     <= c_s[CHUNK];
                overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (psum_s[CHUNK-1] != a_r[WIDTH-1]);
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end
    end

`ifdef SEQ_CHUNK_ADDER_CARRY_VEC_EN
    // Per-bit carries captured alongside the sum chunk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_vec <= '0;
        end else if (state_r == ST_RUN) begin
            carry_vec[int'(idx_r) * CHUNK +: CHUNK] <= c_s[CHUNK:1];
        end
    end
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder (WIDTH=32, CHUNK=8).
module tb_seq_chunk_adder;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
`ifdef SEQ_CHUNK_ADDER_CARRY_VEC_EN
    logic [WIDTH-1:0] carry_vec;
`endif

    int n_cmp = 0;
    int n_err = 0;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ready    (ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
`ifdef SEQ_CHUNK_ADDER_CARRY_VEC_EN
        ,
        .carry_vec(carry_vec)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ov;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef SEQ_CHUNK_ADDER_CARRY_VEC_EN
    function automatic logic [31:0] carries(input logic [31:0] x, input logic [31:0] y, input logic c0);
        logic [31:0] r;
        logic        c;
        c = c0;
        for (int j = 0; j < 32; j++) begin
            c    = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
            r[j] = c;
        end
        return r;
    endfunction
`endif

    // Issue one operation and wait (bounded) for done; lat = edges from acceptance to done
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                          input logic tsub, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_ready_low", {63'd0, ready}, 64'd0);
        check("accept_busy_high", {63'd0, busy}, 64'd1);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
    endtask

    vec_t vecs[9];
    int   lat;
    int   dones;

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

        #12;
        check("rst_sum", {32'd0, sum}, 64'd0);
        check("rst_flags", {60'd0, ready, busy, done, cout}, {60'd0, 4'b1000});
        check("rst_ov", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(NCHUNK));
            check($sformatf("v%0d_sum", i), {32'd0, sum}, {32'd0, vecs[i].exp_sum});
            check($sformatf("v%0d_cout", i), {63'd0, cout}, {63'd0, vecs[i].exp_cout});
            check($sformatf("v%0d_ov", i), {63'd0, overflow}, {63'd0, vecs[i].exp_ov});
`ifdef SEQ_CHUNK_ADDER_CARRY_VEC_EN
            check($sformatf("v%0d_carry_vec", i), {32'd0, carry_vec},
                  {32'd0, carries(vecs[i].a, vecs[i].sub ? ~vecs[i].b : vecs[i].b,
                                  vecs[i].sub ? ~vecs[i].cin : vecs[i].cin)});
`endif
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), {62'd0, done, ready}, {62'd0, 2'b01});
            check($sformatf("v%0d_hold_sum", i), {32'd0, sum}, {32'd0, vecs[i].exp_sum});
        end

`ifdef SEQ_CHUNK_ADDER_CARRY_VEC_EN
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        check("cv_literal", {32'd0, carry_vec}, 64'h0000_0000_7FFF_FFFF);
`endif

        // Requests while busy must be ignored; inputs changing after acceptance have no effect
        @(negedge clk);
        a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h0000_AAAA; b = 32'h0000_5555;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                start = 1'b0;
                check("busy_sum", {32'd0, sum}, 64'd3);
                @(posedge clk);
                #1;
                check("busy_ready_after_done", {63'd0, ready}, 64'd1);
            end
        end
        start = 1'b0;
        check("busy_done_count", 64'(dones), 64'd1);

        // Reset in the middle of RUN aborts with no done pulse
        @(negedge clk);
        while (!ready) @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_sum", {32'd0, sum}, 64'd0);
        check("abort_flags", {60'd0, ready, busy, done, cout}, {60'd0, 4'b1000});
        check("abort_ov", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_idle_ready", {63'd0, ready}, 64'd1);

        run_op(32'd10, 32'd20, 1'b1, 1'b0, lat);
        check("post_abort_latency", 64'(lat), 64'(NCHUNK));
        check("post_abort_sum", {32'd0, sum}, 64'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes CHUNK bits per clock through a registered carry, using the ripple carry chain in time-multiplexed form.
- Takes the place of a flat full-width ripple chain where area matters more than latency.
- Adds carry-in, subtract mode, a start/ready/done handshake, and signed overflow.
- Sits in the datapath next to the ALU and is driven by a controller FSM.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits summed per cycle. NCHUNK = WIDTH/CHUNK; CHUNK=WIDTH gives single-chunk operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when ready=1
- ready  out  1  high in IDLE; block can accept start
- a  in  WIDTH  operand A, latched at acceptance
- b  in  WIDTH  operand B, latched at acceptance
- cin  in  1  carry-in (borrow-in when sub=1), latched at acceptance
- sub  in  1  0: a+b+cin; 1: a-b-cin; latched at acceptance
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result valid
- sum  out  WIDTH  result, held until next acceptance
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  out  1  signed overflow

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. While rst_n=0:
  - state=IDLE, chunk index=0, carry reg=0
  - sum=0, cout=0, overflow=0, done=0, busy=0, ready=1
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN: on the edge E0 where start=1 and ready=1. At E0 latch:
  - A = a
  - B' = sub ? ~b : b
  - carry reg = sub ? ~cin : cin
  - chunk index = 0
- RUN: at each edge, for chunk i = bits [i*CHUNK +: CHUNK]:
  - sum[chunk i] = A[i] + B'[i] + carry reg (low CHUNK bits)
  - carry reg = carry out of that chunk
  - i increments
  - Chunks are processed at edges E1..EN, with N = NCHUNK.
- RUN to DONE: at EN. At that edge also register:
  - cout = final carry
  - overflow = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB])
- DONE: exactly one cycle, done=1. DONE to IDLE at the next edge; done returns to 0 and ready to 1.
- Latency: done is high in the cycle starting at EN, i.e. NCHUNK cycles after the acceptance edge. Throughput is one operation per NCHUNK+2 cycles.
- start while ready=0 (RUN or DONE): ignored, no queuing. Input changes after E0 have no effect.
- sum, cout, overflow:
  - Partial values are visible during RUN.
  - Final values are stable from EN until the next acceptance edge.
- Reset asserted mid-RUN: the operation is aborted immediately and all outputs take reset values. No done pulse follows.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Optional Feature:
- Macro SEQ_CHUNK_ADDER_CARRY_VEC_EN.
- Defined:
  - Adds output carry_vec (WIDTH bits) holding the per-bit internal carry out of every bit position, captured chunk by chunk alongside sum.
  - carry_vec[WIDTH-1] equals cout.
  - Reset value 0; held with sum.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> done 4 cycles after acceptance; sum=0x00000000, cout=1, overflow=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, overflow=1. With CARRY_VEC_EN: carry_vec=0x7FFFFFFF.
- Subtract cases, cin=0, sub=1:
  - a=5, b=7 -> sum=0xFFFFFFFE, cout=0, overflow=0.
  - a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
- Start a=1, b=2, then pulse start with a=0xAAAA, b=0x5555 on each cycle while busy -> second request ignored; sum=0x00000003, one done pulse, ready=1 the cycle after done.
- Start a=0xFFFFFFFF, b=1; drive rst_n=0 after 2 RUN edges -> outputs 0 immediately, ready=1, no done. After release, a=10, b=20, cin=1 -> sum=31.
